// File: rtl/pam_serializer_mc.sv
// Multi-channel PAM/DAC serializer: fetches NUM_CHANNELS samples from a byte FIFO
// into a double buffer and shifts them out MSB-first on sdata/bclk/nsync once per frame.
module pam_serializer_mc #(
  parameter int CLKS_PER_FRAME = 1200,
  parameter int CLKS_PER_BCLK  = 12,
  parameter int FRAME_BITS     = 24,
  parameter int SAMPLE_BYTES   = 2,
  parameter int NUM_CHANNELS   = 2,
  parameter int SIGN_EXTEND    = 0,
  parameter int HOLD_LAST      = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] sample,
  input  logic       empty,
  output logic       read,
  output logic       sdata,
  output logic       bclk,
  output logic       nsync,
  output logic       underflow,
  output logic       frame_active
);

  localparam int NUM_BYTES  = NUM_CHANNELS * SAMPLE_BYTES;
  localparam int SAMPLE_W   = SAMPLE_BYTES * 8;
  localparam int TOTAL_BITS = NUM_CHANNELS * FRAME_BITS;
  localparam int FCNT_W     = $clog2(CLKS_PER_FRAME);
  localparam int PH_W       = $clog2(CLKS_PER_BCLK);
  localparam int BIT_W      = $clog2(TOTAL_BITS);
  localparam int IDX_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(CLKS_PER_FRAME - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_BCLK - 1);
  localparam logic [PH_W-1:0]   PH_HALF   = PH_W'(CLKS_PER_BCLK / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(TOTAL_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_BYTES - 1);

  // FIFO handshake: read is a one-cycle pulse issued only when empty=0;
  // the byte on sample is valid in the following cycle (fetch state F_CAP).
  typedef enum logic [1:0] {F_REQ, F_CAP, F_FULL} fetch_state_t;

  fetch_state_t fetch_state, fetch_next;

  logic [FCNT_W-1:0]          frame_cnt;
  logic                       tick;
  logic                       buf_full;
  logic [IDX_W-1:0]           idx;
  logic [NUM_BYTES-1:0][7:0]  byte_buf;
  logic [NUM_BYTES-1:0][7:0]  buf_next;
  logic [TOTAL_BITS-1:0]      frame_word;
  logic [TOTAL_BITS-1:0]      shift_reg;
  logic [TOTAL_BITS-1:0]      last_reg;
  logic                       shifting;
  logic [PH_W-1:0]            ph_cnt;
  logic [BIT_W-1:0]           bit_cnt;
  logic                       underflow_q;

  function automatic logic [FRAME_BITS-1:0] pad_word(input logic [SAMPLE_W-1:0] s);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[SAMPLE_W-1:0] = s;
    if (SIGN_EXTEND != 0 && s[SAMPLE_W-1]) begin
      for (int j = SAMPLE_W; j < FRAME_BITS; j++) w[j] = 1'b1;
    end
    return w;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (!enable || frame_cnt == FCNT_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  assign tick = enable && (frame_cnt == FCNT_LAST);
  // A last-byte capture coinciding with the tick still counts as a full buffer.
  assign buf_full = (fetch_state == F_FULL) || (fetch_state == F_CAP && idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_state <= F_REQ;
    else        fetch_state <= fetch_next;
  end

  always_comb begin
    fetch_next = fetch_state;
    case (fetch_state)
      F_REQ:   if (enable && !empty) fetch_next = F_CAP;
      F_CAP:   fetch_next = (idx == IDX_LAST) ? F_FULL : F_REQ;
      F_FULL:  fetch_next = F_FULL;
      default: fetch_next = F_REQ;
    endcase
    if (tick && buf_full) fetch_next = F_REQ;
  end

  // rst_n gates the pulse so no read escapes while reset is held.
  always_comb begin
    read = rst_n && enable && (fetch_state == F_REQ) && !empty;
  end

  always_comb begin
    buf_next = byte_buf;
    if (fetch_state == F_CAP) buf_next[idx] = sample;
  end

  always_comb begin
    frame_word = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      frame_word[(NUM_CHANNELS-1-c)*FRAME_BITS +: FRAME_BITS] =
        pad_word(buf_next[c*SAMPLE_BYTES +: SAMPLE_BYTES]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_buf <= '0;
      idx      <= '0;
    end else begin
      byte_buf <= buf_next;
      if (tick && buf_full)           idx <= '0;
      else if (fetch_state == F_CAP)  idx <= idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifting    <= 1'b0;
      ph_cnt      <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      last_reg    <= '0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= tick && !buf_full;
      if (!enable) begin
        shifting <= 1'b0;
        ph_cnt   <= '0;
        bit_cnt  <= '0;
      end else if (tick) begin
        ph_cnt  <= '0;
        bit_cnt <= '0;
        if (buf_full) begin
          shift_reg <= frame_word;
          last_reg  <= frame_word;
          shifting  <= 1'b1;
        end else if (HOLD_LAST != 0) begin
          shift_reg <= last_reg;
          shifting  <= 1'b1;
        end
      end else if (shifting) begin
        if (ph_cnt == PH_LAST) begin
          ph_cnt <= '0;
          if (bit_cnt == BIT_LAST) begin
            shifting <= 1'b0;
          end else begin
            bit_cnt   <= bit_cnt + BIT_W'(1);
            shift_reg <= {shift_reg[TOTAL_BITS-2:0], 1'b0};
          end
        end else begin
          ph_cnt <= ph_cnt + PH_W'(1);
        end
      end
    end
  end

  // Gating with enable makes a disable abort the line in the same cycle.
  assign frame_active = shifting && enable;
  assign nsync        = !frame_active;
  assign bclk         = !frame_active || (ph_cnt < PH_HALF);
  assign sdata        = frame_active && shift_reg[TOTAL_BITS-1];
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_pam_serializer_mc.sv
// Directed bench: two serializer instances (plain / sign-extend+hold-last) fed by
// queue-backed FIFO models, with a line monitor decoding bits on bclk falling edges.
module tb_pam_serializer_mc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en0 = 1'b0, en1 = 1'b0;
  logic [7:0] smp0 = 8'h00, smp1 = 8'h00;
  logic emp0 = 1'b1, emp1 = 1'b1;
  wire rd0, sd0, bc0, ns0, uf0, fa0;
  wire rd1, sd1, bc1, ns1, uf1, fa1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic rdl0 = 1'b0, rdl1 = 1'b0;

  logic [47:0] cap0 = '0, cap1 = '0;
  logic pbc0 = 1'b1, pbc1 = 1'b1;
  int bits0 = 0, bits1 = 0, nsl0 = 0, nsl1 = 0, fac0 = 0, fac1 = 0;
  int ufc0 = 0, ufc1 = 0, rdc0 = 0, rdc1 = 0;

  int n_cmp = 0, n_bad = 0;
  int s_rd, s_bits, s_nsl, s_fa, s_uf;

  always #5 clk = ~clk;

  pam_serializer_mc #(
    .CLKS_PER_FRAME(200), .CLKS_PER_BCLK(4), .FRAME_BITS(24), .SAMPLE_BYTES(2),
    .NUM_CHANNELS(2), .SIGN_EXTEND(0), .HOLD_LAST(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .sample(smp0), .empty(emp0),
    .read(rd0), .sdata(sd0), .bclk(bc0), .nsync(ns0), .underflow(uf0), .frame_active(fa0)
  );

  pam_serializer_mc #(
    .CLKS_PER_FRAME(200), .CLKS_PER_BCLK(4), .FRAME_BITS(24), .SAMPLE_BYTES(2),
    .NUM_CHANNELS(2), .SIGN_EXTEND(1), .HOLD_LAST(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .sample(smp1), .empty(emp1),
    .read(rd1), .sdata(sd1), .bclk(bc1), .nsync(ns1), .underflow(uf1), .frame_active(fa1)
  );

  // FIFO models: the read pulse seen at the last negedge pops a byte at the posedge.
  always @(posedge clk) begin
    if (rdl0 && q0.size() > 0) smp0 <= q0.pop_front();
    emp0 <= (q0.size() == 0);
    if (rdl1 && q1.size() > 0) smp1 <= q1.pop_front();
    emp1 <= (q1.size() == 0);
  end

  always @(negedge clk) begin
    rdl0 <= rd0;
    rdl1 <= rd1;
    if (rd0) rdc0 <= rdc0 + 1;
    if (rd1) rdc1 <= rdc1 + 1;
    if (pbc0 && !bc0 && !ns0) begin cap0 <= {cap0[46:0], sd0}; bits0 <= bits0 + 1; end
    if (pbc1 && !bc1 && !ns1) begin cap1 <= {cap1[46:0], sd1}; bits1 <= bits1 + 1; end
    if (!ns0) nsl0 <= nsl0 + 1;
    if (!ns1) nsl1 <= nsl1 + 1;
    if (fa0) fac0 <= fac0 + 1;
    if (fa1) fac1 <= fac1 + 1;
    if (uf0) ufc0 <= ufc0 + 1;
    if (uf1) ufc1 <= ufc1 + 1;
    pbc0 <= bc0;
    pbc1 <= bc1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 0) q0.push_back(b);
    else          q1.push_back(b);
  endtask

  task automatic wait_ns(input int sel, input logic lvl, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (((sel == 0) ? ns0 : ns1) == lvl) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, {63'd0, seen}, 64'd1);
  endtask

  task automatic snap(input int sel);
    s_rd   = (sel == 0) ? rdc0  : rdc1;
    s_bits = (sel == 0) ? bits0 : bits1;
    s_nsl  = (sel == 0) ? nsl0  : nsl1;
    s_fa   = (sel == 0) ? fac0  : fac1;
    s_uf   = (sel == 0) ? ufc0  : ufc1;
  endtask

  task automatic check_reset_outs(input string tag, input int sel);
    if (sel == 0) begin
      check({tag, "_read0"}, {63'd0, rd0}, 64'd0);
      check({tag, "_sdata0"}, {63'd0, sd0}, 64'd0);
      check({tag, "_bclk0"}, {63'd0, bc0}, 64'd1);
      check({tag, "_nsync0"}, {63'd0, ns0}, 64'd1);
      check({tag, "_uf0"}, {63'd0, uf0}, 64'd0);
      check({tag, "_fa0"}, {63'd0, fa0}, 64'd0);
    end else begin
      check({tag, "_read1"}, {63'd0, rd1}, 64'd0);
      check({tag, "_sdata1"}, {63'd0, sd1}, 64'd0);
      check({tag, "_bclk1"}, {63'd0, bc1}, 64'd1);
      check({tag, "_nsync1"}, {63'd0, ns1}, 64'd1);
      check({tag, "_uf1"}, {63'd0, uf1}, 64'd0);
      check({tag, "_fa1"}, {63'd0, fa1}, 64'd0);
    end
  endtask

  initial begin
    // Reset with data waiting and enable high: read must still stay low.
    #2;
    push(0, 8'h34); push(0, 8'h12); push(0, 8'h78); push(0, 8'h56);
    en0 = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outs("rst", 0);
    check_reset_outs("rst", 1);

    // Basic frame: 34 12 78 56 -> 0x001234, 0x005678.
    snap(0);
    rst_n = 1'b1;
    wait_ns(0, 1'b0, 400, "t1_start");
    wait_ns(0, 1'b1, 400, "t1_end");
    check("t1_reads", 64'(rdc0 - s_rd), 64'd4);
    check("t1_bits", 64'(bits0 - s_bits), 64'd48);
    check("t1_nsync_low", 64'(nsl0 - s_nsl), 64'd192);
    check("t1_active", 64'(fac0 - s_fa), 64'd192);
    check("t1_data", {16'd0, cap0}, {16'd0, 48'h001234_005678});
    check("t1_uf", 64'(ufc0 - s_uf), 64'd0);

    // Empty FIFO at the next tick, skip mode.
    snap(0);
    repeat (100) @(posedge clk);
    #2;
    check("t2_uf", 64'(ufc0 - s_uf), 64'd1);
    check("t2_nsync_low", 64'(nsl0 - s_nsl), 64'd0);
    check("t2_reads", 64'(rdc0 - s_rd), 64'd0);

    // Partial fetch across a tick, then refill.
    snap(0);
    push(0, 8'hAB); push(0, 8'hCD);
    repeat (150) @(posedge clk);
    #2;
    check("t3_uf_mid", 64'(ufc0 - s_uf), 64'd1);
    push(0, 8'h11); push(0, 8'h22);
    wait_ns(0, 1'b0, 400, "t3_start");
    wait_ns(0, 1'b1, 400, "t3_end");
    check("t3_uf", 64'(ufc0 - s_uf), 64'd1);
    check("t3_reads", 64'(rdc0 - s_rd), 64'd4);
    check("t3_bits", 64'(bits0 - s_bits), 64'd48);
    check("t3_data", {16'd0, cap0}, {16'd0, 48'h00CDAB_002211});

    // Hold-last with nothing sent yet: zeros go out.
    snap(1);
    en1 = 1'b1;
    wait_ns(1, 1'b0, 400, "z_start");
    push(1, 8'h00); push(1, 8'h80); push(1, 8'h7F); push(1, 8'h12);
    wait_ns(1, 1'b1, 400, "z_end");
    check("z_uf", 64'(ufc1 - s_uf), 64'd1);
    check("z_bits", 64'(bits1 - s_bits), 64'd48);
    check("z_data", {16'd0, cap1}, 64'd0);

    // Sign-extended frame A: 00 80 -> 0xFF8000, 7F 12 -> 0x00127F.
    s_bits = bits1; s_uf = ufc1;
    wait_ns(1, 1'b0, 400, "a_start");
    wait_ns(1, 1'b1, 400, "a_end");
    check("a_reads", 64'(rdc1 - s_rd), 64'd4);
    check("a_uf", 64'(ufc1 - s_uf), 64'd0);
    check("a_bits", 64'(bits1 - s_bits), 64'd48);
    check("a_data", {16'd0, cap1}, {16'd0, 48'hFF8000_00127F});

    // Underflow with hold-last: frame A repeated bit-identically.
    snap(1);
    wait_ns(1, 1'b0, 400, "h_start");
    wait_ns(1, 1'b1, 400, "h_end");
    check("h_uf", 64'(ufc1 - s_uf), 64'd1);
    check("h_reads", 64'(rdc1 - s_rd), 64'd0);
    check("h_bits", 64'(bits1 - s_bits), 64'd48);
    check("h_nsync_low", 64'(nsl1 - s_nsl), 64'd192);
    check("h_data", {16'd0, cap1}, {16'd0, 48'hFF8000_00127F});

    // Asynchronous reset in the middle of a shift.
    snap(0);
    push(0, 8'h34); push(0, 8'h12); push(0, 8'h78); push(0, 8'h56);
    wait_ns(0, 1'b0, 450, "r_start");
    begin
      logic reached;
      reached = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk); #1;
        if (bits0 - s_bits >= 10) begin
          reached = 1'b1;
          break;
        end
      end
      check("r_bit10", {63'd0, reached}, 64'd1);
    end
    @(posedge clk); #2;
    check("r_pre_active", {63'd0, fa0}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("r_async", 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    snap(0);
    repeat (50) @(posedge clk);
    #2;
    check("r_no_read", 64'(rdc0 - s_rd), 64'd0);
    check("r_idle_nsync", {63'd0, ns0}, 64'd1);
    push(0, 8'h5A);
    repeat (10) @(posedge clk);
    #2;
    check("r_read_after", 64'(rdc0 - s_rd), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
